// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one hex-to-BCD converter between NREQ requesters.
// Optional converter timeout is compiled in with `define BCD_TIMEOUT_EN.
module bcd_conv_arbiter #(
    parameter int NREQ    = 3,
    parameter int H_W     = 6,
    parameter int L_W     = 7,
    parameter int TMO_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*H_W-1:0] req_h,
    input  logic [NREQ*L_W-1:0] req_l,
    output logic [NREQ-1:0]     ack,
    output logic [15:0]         rsp_bcd,
    output logic [2:0]          rsp_id,
    output logic                rsp_err,
    output logic                busy,
    output logic                cv_start,
    output logic [H_W-1:0]      cv_h,
    output logic [L_W-1:0]      cv_l,
    input  logic                cv_done,
    input  logic [15:0]         cv_bcd
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_ptr, r_gnt, w_pick;
    logic            w_any, w_tmo;
    logic [H_W-1:0]  w_h, r_cv_h;
    logic [L_W-1:0]  w_l, r_cv_l;
    logic [NREQ-1:0] w_gnt_oh, r_ack;
    logic [15:0]     r_bcd;
    logic [2:0]      r_id;
    logic            r_busy, r_start;

    // Scan offsets from the far end so the nearest asserted index after ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ((int'(r_ptr) + k == i) || (int'(r_ptr) + k == i + NREQ))) begin
                    w_any  = 1'b1;
                    w_pick = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_h = '0;
        w_l = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == 3'(i)) begin
                w_h = req_h[i*H_W +: H_W];
                w_l = req_l[i*L_W +: L_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) w_gnt_oh[i] = (r_gnt == 3'(i));
    end

`ifdef BCD_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == START)     r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= r_cnt + 8'd1;
            if (r_state == WAIT && w_next == DONE) r_err <= !cv_done;
        end
    end

    // A done arriving on the timeout cycle takes precedence.
    assign w_tmo   = (r_state == WAIT) && !cv_done && (r_cnt == 8'(TMO_CYC - 1));
    assign rsp_err = r_err;
`else
    assign w_tmo   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (cv_done || w_tmo) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cv_h  <= '0;
            r_cv_l  <= '0;
            r_ack   <= '0;
            r_bcd   <= '0;
            r_id    <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == START);
            r_busy  <= (w_next != IDLE);
            r_ack   <= (w_next == DONE) ? w_gnt_oh : '0;
            if (r_state == IDLE && w_any) begin
                r_gnt  <= w_pick;
                r_cv_h <= w_h;
                r_cv_l <= w_l;
            end
            if (r_state == WAIT && w_next == DONE) begin
                r_bcd <= cv_done ? cv_bcd : 16'hEEEE;
                r_id  <= r_gnt;
            end
            if (r_state == DONE) r_ptr <= (r_gnt == 3'(NREQ - 1)) ? 3'd0 : r_gnt + 3'd1;
        end
    end

    assign ack      = r_ack;
    assign rsp_bcd  = r_bcd;
    assign rsp_id   = r_id;
    assign busy     = r_busy;
    assign cv_start = r_start;
    assign cv_h     = r_cv_h;
    assign cv_l     = r_cv_l;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: vector table, directed corner sequences and a
// randomized run checked by a grant/result scoreboard with a converter model.
module tb_bcd_conv_arbiter;
    localparam int NREQ = 3;
    localparam int H_W  = 6;
    localparam int L_W  = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*H_W-1:0] req_h;
    logic [NREQ*L_W-1:0] req_l;
    logic [NREQ-1:0]     ack;
    logic [15:0]         rsp_bcd;
    logic [2:0]          rsp_id;
    logic                rsp_err, busy, cv_start;
    logic [H_W-1:0]      cv_h;
    logic [L_W-1:0]      cv_l;
    logic                cv_done;
    logic [15:0]         cv_bcd;

    logic        m_done = 1'b0, s_done = 1'b0;
    logic [15:0] m_bcd  = 16'hDEAD;
    assign cv_done = m_done | s_done;
    assign cv_bcd  = s_done ? 16'h1111 : m_bcd;

    int errors = 0, checks = 0;
    int cdly = 5;
    bit rnd_dly = 1'b0, conv_en = 1'b1;

    bcd_conv_arbiter #(.NREQ(NREQ), .H_W(H_W), .L_W(L_W), .TMO_CYC(255)) dut (
        .clk(clk), .rst(rst), .req(req), .req_h(req_h), .req_l(req_l),
        .ack(ack), .rsp_bcd(rsp_bcd), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy), .cv_start(cv_start), .cv_h(cv_h), .cv_l(cv_l),
        .cv_done(cv_done), .cv_bcd(cv_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int h, input int l);
        return {4'(h / 10), 4'(h % 10), 4'(l / 10), 4'(l % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Converter model: done D cycles after the start cycle, result = decimal digits.
    int          crem;
    bit          cpend = 1'b0;
    logic [15:0] cres;
    always @(negedge clk) begin
        m_done = 1'b0;
        m_bcd  = 16'hDEAD;
        if (!rst) cpend = 1'b0;
        else if (cpend) begin
            crem--;
            if (crem == 0) begin
                m_done = 1'b1;
                m_bcd  = cres;
                cpend  = 1'b0;
            end
        end else if (cv_start && conv_en) begin
            cpend = 1'b1;
            crem  = rnd_dly ? int'($urandom_range(9, 2)) : cdly;
            cres  = bcd(int'(cv_h), int'(cv_l));
        end
    end

    // Scoreboard: who should win each grant, and what the ack must carry.
    logic [NREQ-1:0] p_req = '0, ack_seen = '0;
    int          p_h[NREQ], p_l[NREQ];
    bit          pend = 1'b0, eerr = 1'b0;
    int          eid = 0, mptr = 0, pick, idx;
    logic [15:0] ebcd = '0, last_bcd = '0;
    always @(negedge clk) begin
        if (!rst) begin
            pend = 1'b0; mptr = 0; last_bcd = '0;
        end else begin
            if (ack != '0) begin
                chk("ack_expected", 32'(pend), 1);
                chk("ack_onehot", 32'(ack), 32'(1 << eid));
                chk("rsp_id", 32'(rsp_id), 32'(eid));
                chk("rsp_bcd", 32'(rsp_bcd), 32'(ebcd));
                chk("rsp_err", 32'(rsp_err), 32'(eerr));
                pend = 1'b0; mptr = (eid + 1) % NREQ; last_bcd = ebcd;
            end else begin
                chk("bcd_hold", 32'(rsp_bcd), 32'(last_bcd));
            end
            if (cv_start) begin
                pick = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    if (pick < 0 && p_req[idx]) pick = idx;
                end
                chk("grant_valid", 32'(pick >= 0), 1);
                chk("start_while_busy", 32'(pend), 0);
                if (pick < 0) pick = 0;
                chk("cv_h", 32'(cv_h), 32'(p_h[pick]));
                chk("cv_l", 32'(cv_l), 32'(p_l[pick]));
                pend = 1'b1; eid = pick; eerr = !conv_en;
                ebcd = conv_en ? bcd(p_h[pick], p_l[pick]) : 16'hEEEE;
            end
        end
        ack_seen = ack;
        p_req    = req;
        for (int i = 0; i < NREQ; i++) begin
            p_h[i] = int'(req_h[i*H_W +: H_W]);
            p_l[i] = int'(req_l[i*L_W +: L_W]);
        end
    end

    logic [NREQ-1:0] tk_drop;
    bit tk_ack;
    int tk_id;
    // One cycle of requester behaviour: drop req on the edge that samples own ack.
    task automatic tick();
        @(posedge clk); #1;
        tk_drop = ack_seen;
        tk_ack  = (ack_seen != '0);
        tk_id   = 0;
        for (int i = 0; i < NREQ; i++) if (ack_seen[i]) begin req[i] = 1'b0; tk_id = i; end
    endtask

    task automatic set_ops(input int i, input int h, input int l);
        req_h[i*H_W +: H_W] = H_W'(h);
        req_l[i*L_W +: L_W] = L_W'(l);
    endtask

    task automatic wait_neg(input bit on_ack, input int bound, output int n);
        n = 0;
        forever begin
            @(negedge clk); n++;
            if ((on_ack && ack != '0) || (!on_ack && cv_start)) break;
            if (n >= bound) begin n = -1; break; end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((busy || req != '0) && n < bound) begin tick(); n++; end
        chk("drain_timeout", 32'(n < bound), 1);
        tick();
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b0; req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0] rq; int h; int l; int dly;
        logic [NREQ-1:0] ak; logic [15:0] bc; int id;
    } vec_t;

    initial begin
        vec_t vt[6];
        int   n, lows, phase;
        bit   hold0;
        int   ids[$];

        vt[0] = '{3'b001, 59, 99, 20, 3'b001, 16'h5999, 0};
        vt[1] = '{3'b101, 12, 34,  2, 3'b100, 16'h1234, 2};
        vt[2] = '{3'b110,  0,  0,  5, 3'b010, 16'h0000, 1};
        vt[3] = '{3'b011, 45,  7,  3, 3'b001, 16'h4507, 0};
        vt[4] = '{3'b100,  9, 60,  2, 3'b100, 16'h0960, 2};
        vt[5] = '{3'b111, 30, 15,  7, 3'b001, 16'h3015, 0};

        rst = 1'b0; req = '0; req_h = '0; req_l = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_bcd", 32'(rsp_bcd), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(cv_start), 0);
        chk("rst_cv_h", 32'(cv_h), 0);
        chk("rst_cv_l", 32'(cv_l), 0);
        @(posedge clk); #1 rst = 1'b1;

        foreach (vt[r]) begin
            @(posedge clk); #1;
            req = vt[r].rq; cdly = vt[r].dly;
            for (int i = 0; i < NREQ; i++) set_ops(i, vt[r].h, vt[r].l);
            wait_neg(1'b0, 10, n);
            chk("row_start_lat", 32'(n), 2);
            chk("row_cv_h", 32'(cv_h), 32'(vt[r].h));
            wait_neg(1'b1, 100, n);
            chk("row_ack_lat", 32'(n), 32'(vt[r].dly + 1));
            chk("row_ack", 32'(ack), 32'(vt[r].ak));
            chk("row_bcd", 32'(rsp_bcd), 32'(vt[r].bc));
            chk("row_id", 32'(rsp_id), 32'(vt[r].id));
            @(posedge clk); #1 req = '0;
        end

        // done pulses in IDLE and START must not produce a result
        drain(50);
        req = 3'b001; set_ops(0, 21, 43); cdly = 6; s_done = 1'b1;
        @(posedge clk); #1;
        chk("spur_start", 32'(cv_start), 1);
        @(posedge clk); #1 s_done = 1'b0;
        wait_neg(1'b1, 50, n);
        chk("spur_ack_lat", 32'(n), 7);
        chk("spur_bcd", 32'(rsp_bcd), 32'h2143);
        @(posedge clk); #1 req = '0;

        // three simultaneous requesters from ptr=0
        do_reset();
        tick();
        req = 3'b111; cdly = 3;
        for (int i = 0; i < NREQ; i++) set_ops(i, 10 + i, 20 + i);
        lows = 0; n = 0;
        while (ids.size() < 3 && n < 200) begin
            tick(); n++;
            if (tk_ack) ids.push_back(tk_id);
            if (ids.size() == 3) break;
            if (!busy) lows++;
        end
        chk("sim_count", 32'(ids.size()), 3);
        chk("sim_order0", 32'(ids[0]), 0);
        chk("sim_order1", 32'(ids[1]), 1);
        chk("sim_order2", 32'(ids[2]), 2);
        chk("sim_idle_gaps", 32'(lows), 2);
        drain(50);

        // fairness: req0 keeps coming back, req2 raised once
        ids.delete();
        req = 3'b001; set_ops(0, 1, 2); set_ops(2, 33, 44); cdly = 4;
        hold0 = 1'b0; phase = 0; n = 0;
        while (ids.size() < 2 && n < 300) begin
            tick(); n++;
            if (tk_ack) begin
                if (phase == 0) begin
                    chk("fair_first", 32'(tk_id), 0);
                    phase = 1; req[2] = 1'b1;
                end else ids.push_back(tk_id);
            end
            if (ids.size() < 2 && !req[0]) begin
                if (hold0) begin req[0] = 1'b1; hold0 = 1'b0; end
                else hold0 = 1'b1;
            end
        end
        chk("fair_count", 32'(ids.size()), 2);
        chk("fair_req2", 32'(ids[0]), 2);
        chk("fair_wrap", 32'(ids[1]), 0);
        req = '0;
        drain(100);

        // reset in WAIT aborts; held req0 restarts cleanly
        req = 3'b001; set_ops(0, 7, 8); cdly = 30;
        wait_neg(1'b0, 10, n);
        chk("rw_start_lat", 32'(n), 2);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("rw_ack", 32'(ack), 0);
        chk("rw_busy", 32'(busy), 0);
        chk("rw_bcd", 32'(rsp_bcd), 0);
        chk("rw_cv_h", 32'(cv_h), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_neg(1'b0, 10, n);
        chk("rw_restart", 32'(n), 2);
        wait_neg(1'b1, 100, n);
        chk("rw_ack_lat", 32'(n), 31);
        chk("rw_result", 32'(rsp_bcd), 32'h0708);
        @(posedge clk); #1 req = '0;

`ifdef BCD_TIMEOUT_EN
        drain(50);
        conv_en = 1'b0; req = 3'b010; set_ops(1, 11, 22);
        wait_neg(1'b0, 10, n);
        chk("tmo_start_lat", 32'(n), 2);
        wait_neg(1'b1, 400, n);
        chk("tmo_ack_lat", 32'(n), 256);
        chk("tmo_err", 32'(rsp_err), 1);
        chk("tmo_bcd", 32'(rsp_bcd), 32'hEEEE);
        @(posedge clk); #1 req = '0; conv_en = 1'b1; cdly = 4;
        @(posedge clk); #1 req = 3'b100; set_ops(2, 5, 6);
        wait_neg(1'b0, 10, n);
        chk("tmo_next_start", 32'(n), 2);
        wait_neg(1'b1, 100, n);
        chk("tmo_next_lat", 32'(n), 5);
        chk("tmo_next_err", 32'(rsp_err), 0);
        chk("tmo_next_bcd", 32'(rsp_bcd), 32'h0506);
        @(posedge clk); #1 req = '0;
`endif

        // randomized traffic against the scoreboard
        drain(50);
        rnd_dly = 1'b1;
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && !tk_drop[i] && $urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    set_ops(i, int'($urandom_range(59)), int'($urandom_range(99)));
                end else if ($urandom_range(7) == 0) begin
                    set_ops(i, int'($urandom_range(59)), int'($urandom_range(99)));
                end
            end
        end
        drain(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
